// File: rtl/raster_timing_pkg.sv
// Shared VIC-II beam timing constants keyed by chip code; also used by the
// border, sprite and fetch blocks.
package raster_timing_pkg;

  localparam int CHIP_6569     = 0;
  localparam int CHIP_6567R8   = 1;
  localparam int CHIP_6567R56A = 2;

  localparam logic [6:0] CYCLES_6569     = 7'd63;
  localparam logic [6:0] CYCLES_6567R8   = 7'd65;
  localparam logic [6:0] CYCLES_6567R56A = 7'd64;

  localparam logic [8:0] LINES_6569     = 9'd312;
  localparam logic [8:0] LINES_6567R8   = 9'd263;
  localparam logic [8:0] LINES_6567R56A = 9'd262;

  localparam logic [9:0] XSTART_6569 = 10'h194;
  localparam logic [9:0] XSTART_6567 = 10'h19C;

  localparam logic [9:0] XWRAP_6569     = 10'd504;
  localparam logic [9:0] XWRAP_6567R8   = 10'd520;
  localparam logic [9:0] XWRAP_6567R56A = 10'd512;

  // 6567R8: xpos rolls over 0x1FF after 100 dots, then freezes for 9 dots
  // before the tail of the line continues at a fixed offset.
  localparam logic [9:0] R8_WRAP_DOT       = 10'd100;
  localparam logic [9:0] R8_STALL_FIRST    = 10'd488;
  localparam logic [9:0] R8_STALL_LAST     = 10'd496;
  localparam logic [9:0] R8_STALL_XPOS     = 10'h184;
  localparam logic [9:0] R8_POST_STALL_OFS = 10'd108;

  function automatic logic [6:0] chip_cycles(input int chip);
    case (chip)
      CHIP_6569:     chip_cycles = CYCLES_6569;
      CHIP_6567R8:   chip_cycles = CYCLES_6567R8;
      CHIP_6567R56A: chip_cycles = CYCLES_6567R56A;
      default:       chip_cycles = CYCLES_6569;
    endcase
  endfunction

  function automatic logic [8:0] chip_lines(input int chip);
    case (chip)
      CHIP_6569:     chip_lines = LINES_6569;
      CHIP_6567R8:   chip_lines = LINES_6567R8;
      CHIP_6567R56A: chip_lines = LINES_6567R56A;
      default:       chip_lines = LINES_6569;
    endcase
  endfunction

  function automatic logic [9:0] chip_xstart(input int chip);
    case (chip)
      CHIP_6569:     chip_xstart = XSTART_6569;
      CHIP_6567R8:   chip_xstart = XSTART_6567;
      CHIP_6567R56A: chip_xstart = XSTART_6567;
      default:       chip_xstart = XSTART_6569;
    endcase
  endfunction

  function automatic logic [9:0] chip_xwrap(input int chip);
    case (chip)
      CHIP_6569:     chip_xwrap = XWRAP_6569;
      CHIP_6567R8:   chip_xwrap = XWRAP_6567R8;
      CHIP_6567R56A: chip_xwrap = XWRAP_6567R56A;
      default:       chip_xwrap = XWRAP_6569;
    endcase
  endfunction

  function automatic logic chip_has_stall(input int chip);
    case (chip)
      CHIP_6567R8: chip_has_stall = 1'b1;
      default:     chip_has_stall = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/raster_timing_xpos_gen.sv
// Maps a phi cycle index and dot-within-cycle to the sprite x coordinate
// for the selected chip, including the 6567R8 stall window.
module raster_timing_xpos_gen
  import raster_timing_pkg::*;
#(
  parameter int CHIP = CHIP_6569
) (
  input  logic [6:0] cycle_num,
  input  logic [2:0] dot_sel,
  output logic [9:0] xpos
);

  localparam logic [9:0] XSTART    = chip_xstart(CHIP);
  localparam logic [9:0] XWRAP     = chip_xwrap(CHIP);
  localparam logic       HAS_STALL = chip_has_stall(CHIP);

  logic [9:0] dot_s;
  logic [9:0] sum_s;

  assign dot_s = {cycle_num, 3'b000} + {7'd0, dot_sel};
  assign sum_s = XSTART + dot_s;

  // Select the dot-to-xpos mapping for this chip.
  always_comb begin
    xpos = sum_s;
    if (HAS_STALL) begin
      if (dot_s < R8_WRAP_DOT) begin
        xpos = sum_s;
      end else if (dot_s < R8_STALL_FIRST) begin
        xpos = dot_s - R8_WRAP_DOT;
      end else if (dot_s <= R8_STALL_LAST) begin
        xpos = R8_STALL_XPOS;
      end else begin
        xpos = dot_s - R8_POST_STALL_OFS;
      end
    end else if (sum_s >= XWRAP) begin
      xpos = sum_s - XWRAP;
    end else begin
      xpos = sum_s;
    end
  end

endmodule

// File: rtl/raster_timing.sv
// VIC-II master beam-position generator: phase, phi cycle and raster line
// counters, registered xpos and the raster compare IRQ pulse.
module raster_timing
  import raster_timing_pkg::*;
#(
  parameter int CHIP = CHIP_6569
) (
  input  logic       clk_dot4x,
  input  logic       rst,
  input  logic [8:0] raster_cmp,
  output logic       clk_phi,
  output logic [4:0] phase,
  output logic       dot_tick,
  output logic [6:0] cycle_num,
  output logic [9:0] xpos,
  output logic [8:0] raster_line,
  output logic       irq_raster
);

  localparam logic [6:0] CYCLE_LAST = chip_cycles(CHIP) - 7'd1;
  localparam logic [8:0] LINE_LAST  = chip_lines(CHIP) - 9'd1;
  localparam logic [9:0] XSTART     = chip_xstart(CHIP);

  logic [4:0] phase_nx_s;
  logic [6:0] cycle_nx_s;
  logic [8:0] line_nx_s;
  logic [9:0] xpos_nx_s;
  logic       line_start_nx_s;

  // Next counter values; every output is registered from these so the
  // counters and xpos never skew against each other.
  always_comb begin
    phase_nx_s = phase + 5'd1;
    cycle_nx_s = cycle_num;
    line_nx_s  = raster_line;
    if (phase == 5'd31) begin
      if (cycle_num == CYCLE_LAST) begin
        cycle_nx_s = 7'd0;
        if (raster_line == LINE_LAST) begin
          line_nx_s = 9'd0;
        end else begin
          line_nx_s = raster_line + 9'd1;
        end
      end else begin
        cycle_nx_s = cycle_num + 7'd1;
      end
    end else begin
      cycle_nx_s = cycle_num;
    end
  end

  assign line_start_nx_s = (phase_nx_s == 5'd0) && (cycle_nx_s == 7'd0);

  raster_timing_xpos_gen #(
    .CHIP(CHIP)
  ) xpos_gen (
    .cycle_num(cycle_nx_s),
    .dot_sel  (phase_nx_s[4:2]),
    .xpos     (xpos_nx_s)
  );

  // Counter and output registers.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      phase       <= 5'd0;
      clk_phi     <= 1'b0;
      dot_tick    <= 1'b1;
      cycle_num   <= 7'd0;
      raster_line <= 9'd0;
      xpos        <= XSTART;
      irq_raster  <= 1'b0;
    end else begin
      phase       <= phase_nx_s;
      clk_phi     <= phase_nx_s[4];
      dot_tick    <= (phase_nx_s[1:0] == 2'b00);
      cycle_num   <= cycle_nx_s;
      raster_line <= line_nx_s;
      xpos        <= xpos_nx_s;
      irq_raster  <= line_start_nx_s && (line_nx_s == raster_cmp);
    end
  end

endmodule

// File: tb/tb_raster_timing.sv
// Self-checking bench: all three chip models run side by side against a
// tick-count based reference model, plus directed boundary checks.
module tb_raster_timing;

  logic       clk_dot4x = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] cmp_v[3];
  logic       clk_phi_o[3];
  logic [4:0] phase_o[3];
  logic       dot_tick_o[3];
  logic [6:0] cycle_o[3];
  logic [9:0] xpos_o[3];
  logic [8:0] line_o[3];
  logic       irq_o[3];

  int checks = 0;
  int errors = 0;
  int t = 0;
  int off[3] = '{0, 0, 0};
  int pulses[3] = '{0, 0, 0};
  int cmp_edge[3] = '{0, 0, 0};
  int cyc_n[3] = '{63, 65, 64};
  int lin_n[3] = '{312, 263, 262};

  always #5 clk_dot4x = ~clk_dot4x;

  raster_timing #(.CHIP(0)) u_pal (
    .clk_dot4x(clk_dot4x), .rst(rst), .raster_cmp(cmp_v[0]),
    .clk_phi(clk_phi_o[0]), .phase(phase_o[0]), .dot_tick(dot_tick_o[0]),
    .cycle_num(cycle_o[0]), .xpos(xpos_o[0]), .raster_line(line_o[0]),
    .irq_raster(irq_o[0]));

  raster_timing #(.CHIP(1)) u_r8 (
    .clk_dot4x(clk_dot4x), .rst(rst), .raster_cmp(cmp_v[1]),
    .clk_phi(clk_phi_o[1]), .phase(phase_o[1]), .dot_tick(dot_tick_o[1]),
    .cycle_num(cycle_o[1]), .xpos(xpos_o[1]), .raster_line(line_o[1]),
    .irq_raster(irq_o[1]));

  raster_timing #(.CHIP(2)) u_r56 (
    .clk_dot4x(clk_dot4x), .rst(rst), .raster_cmp(cmp_v[2]),
    .clk_phi(clk_phi_o[2]), .phase(phase_o[2]), .dot_tick(dot_tick_o[2]),
    .cycle_num(cycle_o[2]), .xpos(xpos_o[2]), .raster_line(line_o[2]),
    .irq_raster(irq_o[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic int xref(input int chip, input int d);
    if (chip == 1) begin
      if (d < 100) return 'h19C + d;
      else if (d < 488) return d - 100;
      else if (d <= 496) return 'h184;
      else return d - 108;
    end else if (chip == 0) begin
      return ('h194 + d) % 504;
    end else begin
      return ('h19C + d) % 512;
    end
  endfunction

  // Reference: every output follows from the tick count since reset.
  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int ph;
      int cy;
      int ln;
      int d;
      int irq;
      ph  = t % 32;
      cy  = (t / 32) % cyc_n[i];
      ln  = (t / (32 * cyc_n[i]) + off[i]) % lin_n[i];
      d   = cy * 8 + ph / 4;
      irq = (t > 0 && ph == 0 && cy == 0 && ln == cmp_edge[i]) ? 1 : 0;
      chk($sformatf("phase%0d", i), phase_o[i], ph);
      chk($sformatf("clk_phi%0d", i), clk_phi_o[i], (ph >= 16) ? 1 : 0);
      chk($sformatf("dot_tick%0d", i), dot_tick_o[i], (ph % 4 == 0) ? 1 : 0);
      chk($sformatf("cycle%0d", i), cycle_o[i], cy);
      chk($sformatf("line%0d", i), line_o[i], ln);
      chk($sformatf("xpos%0d", i), xpos_o[i], xref(i, d));
      chk($sformatf("irq%0d", i), irq_o[i], irq);
      if (irq_o[i] === 1'b1) pulses[i]++;
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_dot4x);
      for (int i = 0; i < 3; i++) cmp_edge[i] = int'(cmp_v[i]);
      if (rst) begin
        t = 0;
        for (int i = 0; i < 3; i++) off[i] = 0;
      end else begin
        t++;
      end
      #1;
      check_all();
    end
  endtask

  task automatic run_to(input int target);
    if (target > t) step(target - t);
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < 3; i++) pulses[i] = 0;
  endtask

  initial begin
    int rnd_cmp;
    int rnd_ph;

    // Part A: reset release, first line on every chip, raster compare.
    rnd_cmp = int'($urandom_range(5, 1));
    cmp_v[0] = 9'd5;
    cmp_v[1] = 9'd7;
    cmp_v[2] = 9'(rnd_cmp);
    rst = 1'b1;
    step(2);
    chk("rst_phase", phase_o[0], 0);
    chk("rst_clk_phi", clk_phi_o[0], 0);
    chk("rst_dot_tick", dot_tick_o[0], 1);
    chk("rst_xpos_pal", xpos_o[0], 'h194);
    chk("rst_xpos_r8", xpos_o[1], 'h19C);
    chk("rst_irq", irq_o[0], 0);
    rst = 1'b0;
    clear_pulses();
    run_to(16);
    chk("tick16_clk_phi", clk_phi_o[0], 1);
    run_to(32);
    chk("tick32_cycle", cycle_o[0], 1);
    chk("tick32_xpos", xpos_o[0], 'h19C);
    run_to(396);
    chk("pal_d99_xpos", xpos_o[0], 'h1F7);
    run_to(400);
    chk("pal_d100_xpos", xpos_o[0], 0);
    run_to(1952);
    chk("r8_d488_xpos", xpos_o[1], 'h184);
    run_to(1987);
    chk("r8_d496_xpos", xpos_o[1], 'h184);
    run_to(1988);
    chk("r8_d497_xpos", xpos_o[1], 'h185);
    run_to(2015);
    chk("pal_last_cycle", cycle_o[0], 62);
    run_to(2016);
    chk("pal_wrap_cycle", cycle_o[0], 0);
    chk("pal_wrap_line", line_o[0], 1);
    run_to(2047);
    chk("r56_last_cycle", cycle_o[2], 63);
    run_to(2048);
    chk("r56_wrap_cycle", cycle_o[2], 0);
    chk("r56_wrap_line", line_o[2], 1);
    run_to(2076);
    chk("r8_d519_xpos", xpos_o[1], 'h19B);
    run_to(2080);
    chk("r8_line_start_xpos", xpos_o[1], 'h19C);
    chk("r8_wrap_line", line_o[1], 1);
    run_to(10080);
    chk("pal_irq_line5", irq_o[0], 1);
    run_to(10081);
    chk("pal_irq_one_tick", irq_o[0], 0);
    run_to(11100);
    cmp_v[1] = 9'd5;
    run_to(13000);
    chk("pal_irq_count", pulses[0], 1);
    chk("r8_midline_cmp_count", pulses[1], 0);
    chk("r56_rand_cmp_count", pulses[2], 1);

    // Part B: frame wrap, start every chip on its last line.
    for (int i = 0; i < 3; i++) cmp_v[i] = 9'd0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    clear_pulses();
    step(1);
    force u_pal.raster_line = 9'd311;
    force u_r8.raster_line = 9'd262;
    force u_r56.raster_line = 9'd261;
    for (int i = 0; i < 3; i++) off[i] = lin_n[i] - 1;
    step(1);
    release u_pal.raster_line;
    release u_r8.raster_line;
    release u_r56.raster_line;
    run_to(2047);
    chk("r56_frame_last_line", line_o[2], 261);
    chk("r56_frame_last_cycle", cycle_o[2], 63);
    run_to(2048);
    chk("r56_frame_wrap_line", line_o[2], 0);
    chk("r56_frame_wrap_cycle", cycle_o[2], 0);
    chk("r56_frame_wrap_irq", irq_o[2], 1);
    run_to(2100);
    chk("pal_frame_irq_count", pulses[0], 1);
    chk("r8_frame_irq_count", pulses[1], 1);
    chk("r56_frame_irq_count", pulses[2], 1);

    // Part C: reset in the middle of line 100, cycle 30.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    clear_pulses();
    step(1);
    force u_pal.raster_line = 9'd100;
    force u_r8.raster_line = 9'd100;
    force u_r56.raster_line = 9'd100;
    for (int i = 0; i < 3; i++) off[i] = 100;
    step(1);
    release u_pal.raster_line;
    release u_r8.raster_line;
    release u_r56.raster_line;
    rnd_ph = int'($urandom_range(31, 0));
    run_to(30 * 32 + rnd_ph);
    chk("pre_rst_line", line_o[0], 100);
    chk("pre_rst_cycle", cycle_o[1], 30);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_line%0d", i), line_o[i], 0);
      chk($sformatf("midrst_cycle%0d", i), cycle_o[i], 0);
      chk($sformatf("midrst_irq%0d", i), irq_o[i], 0);
    end
    chk("midrst_xpos_r56", xpos_o[2], 'h19C);
    run_to(100);
    chk("midrst_pal_pulses", pulses[0], 0);
    chk("midrst_r8_pulses", pulses[1], 0);
    chk("midrst_r56_pulses", pulses[2], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
